// File: rtl/chained_connection_block.sv
// Unidirectional connection block: straight-through E/W tracks plus
// CONTROLIN selectable control outputs, configured over a serial daisy
// chain with a shadow register and an atomic, length-checked commit.
module chained_connection_block #(
   parameter int W          = 8,
   parameter int CONTROLIN  = 6,
   parameter int SEL_PER_IN = $clog2(W*2),
   parameter int FIELD      = SEL_PER_IN + 2,
   parameter int CONF_WIDTH = FIELD*CONTROLIN,
   parameter int CNT_W      = $clog2(CONF_WIDTH+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [W-1:0]         east_in,
   input  logic [W-1:0]         west_in,
   output logic [W-1:0]         east_out,
   output logic [W-1:0]         west_out,
   output logic [CONTROLIN-1:0] control_input,
   input  logic                 cfg_in,
   input  logic                 cfg_shift,
   input  logic                 cfg_commit,
   output logic                 cfg_out,
   output logic                 cfg_full,
   output logic                 cfg_err
);

   // Source vector padded to the full select range; unused codes read 0.
   localparam int NSRC = 1 << SEL_PER_IN;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CONF_WIDTH);

   logic [CONF_WIDTH-1:0] shadow_q, shadow_d;
   logic [CONF_WIDTH-1:0] active_q, active_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic [CONTROLIN-1:0]  q_q;
   logic [CONTROLIN-1:0]  mux_val;
   logic [NSRC-1:0]       src_pad;
   logic                  commit_ok;

   // Tracks pass straight through regardless of configuration or reset.
   assign east_out = west_in;
   assign west_out = east_in;

   assign cfg_out  = shadow_q[0];
   assign cfg_full = (cnt_q == CNT_FULL);
   assign cfg_err  = err_q;

   // A commit is accepted only on a complete frame with no concurrent shift.
   assign commit_ok = cfg_commit && !cfg_shift && (cnt_q == CNT_FULL);

   // Build the zero-padded source vector {west_in, east_in}.
   always_comb begin
      src_pad            = '0;
      src_pad[2*W-1:0]   = {west_in, east_in};
   end

   // Next-state logic for the config chain, counter and error pulse.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      if (cfg_shift) begin
         shadow_d = {cfg_in, shadow_q[CONF_WIDTH-1:1]};
         if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (commit_ok) begin
         active_d = shadow_q;
         cnt_d    = '0;
      end else if (cfg_commit) begin
         err_d = 1'b1;
      end
   end

   // Configuration state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Per-output pipeline flops always follow the mux, independent of mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= mux_val;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CONTROLIN; gi++) begin : g_out
         logic [SEL_PER_IN-1:0] sel;
         logic                  en;
         logic                  rg;
         assign sel = active_q[FIELD*gi +: SEL_PER_IN];
         assign en  = active_q[FIELD*gi + SEL_PER_IN];
         assign rg  = active_q[FIELD*gi + SEL_PER_IN + 1];
         assign mux_val[gi]       = en & src_pad[sel];
         assign control_input[gi] = rg ? q_q[gi] : mux_val[gi];
      end
   endgenerate

endmodule

// File: doc/chained_connection_block.md
Name: chained_connection_block

Overview:
- Next-generation unidirectional connection block for the fabric routing channel.
- Passes W east/west tracks straight through and drives CONTROLIN control inputs into the adjacent logic block. Each control input is selected from any of the 2*W tracks.
- Adds per-input enable and per-input registered/combinational mode.
- Configuration is loaded over a serial daisy-chain into a shadow register, then committed atomically into the active register. A frame-length check guards the commit.

Parameters:
- W, 8, tracks per direction (W >= 1).
- CONTROLIN, 6, number of control outputs.
- SEL_PER_IN, $clog2(W*2), select-field width per output.
- FIELD, SEL_PER_IN+2, config bits per output: sel, en, reg.
- CONF_WIDTH, FIELD*CONTROLIN, total config frame length.
- CNT_W, $clog2(CONF_WIDTH+1), width of the frame counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- east_in  input  W  tracks arriving from the east.
- west_in  input  W  tracks arriving from the west.
- east_out  output  W  equals west_in, combinational.
- west_out  output  W  equals east_in, combinational.
- control_input  output  CONTROLIN  control signals to the logic block.
- cfg_in  input  1  serial config data.
- cfg_shift  input  1  shift-enable for the config chain.
- cfg_commit  input  1  request to copy shadow into active.
- cfg_out  output  1  serial chain output to the next block; equals shadow[0].
- cfg_full  output  1  high when frame counter == CONF_WIDTH.
- cfg_err  output  1  one-cycle pulse on a rejected commit.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high: state clears on the rising clk edge where rst=1, and rst has priority over every other input.
- Reset values:
  - shadow = 0, active = 0, counter = 0.
  - All per-output flops q[i] = 0, cfg_err = 0.
  - Hence control_input = 0, cfg_out = 0, cfg_full = 0.
- Active field layout for output i, with base b = FIELD*i:
  - sel = active[b+SEL_PER_IN-1 : b]
  - en = active[b+SEL_PER_IN]
  - reg = active[b+SEL_PER_IN+1]
- Source vector: src = {west_in, east_in}.
  - sel k < W selects east_in[k].
  - W <= k < 2W selects west_in[k-W].
  - k >= 2W (only possible when 2W is not a power of 2) selects 0.
- Mux output m[i] = en ? src[sel] : 0.
- q[i] <= m[i] every cycle, not gated by any enable.
- control_input[i] = reg ? q[i] : m[i].
  - reg=1 gives exactly 1-cycle latency from track to output.
  - reg=0 is combinational.
- Shift: when cfg_shift=1, shadow <= {cfg_in, shadow[CONF_WIDTH-1:1]}.
  - Frames are sent LSB-first, so the first bit shifted in lands in bit 0 after CONF_WIDTH shifts.
  - counter <= min(counter+1, CONF_WIDTH), saturating.
  - Overlong streams keep only the last CONF_WIDTH bits; counter stays at CONF_WIDTH.
- cfg_out is registered (shadow[0]) and updates only on shift. Chaining N blocks needs N*CONF_WIDTH shifts.
- Commit rules, evaluated only when cfg_commit=1:
  - cfg_shift=0 and counter == CONF_WIDTH: active <= shadow, counter <= 0, shadow is retained. New settings take effect at control_input the cycle after the edge (plus 1 more cycle for reg=1 outputs, whose flop refills from the new mux).
  - counter != CONF_WIDTH: no state change; cfg_err=1 for the next cycle only.
  - cfg_shift=1 in the same cycle: the shift is performed, the commit is rejected and cfg_err pulses.
- Holding cfg_commit high for several cycles:
  - The first valid commit clears the counter.
  - Each subsequent cycle is rejected, and cfg_err stays high while cfg_commit is held.
- Reset mid-frame discards a partial shadow and clears the active config. No partial configuration is ever visible at control_input.
- Track pass-through is unaffected by configuration, reset or the chain.

Test Plan:
- Defaults W=8, CONTROLIN=6, FIELD=6, CONF_WIDTH=36 throughout.
- Reset then idle: east_in=8'hA5, west_in=8'h3C → control_input=0, east_out=8'h3C, west_out=8'hA5, cfg_full=0, cfg_err=0.
- Program all outputs en=1, reg=0 with sel[i]=i, then shift 36 bits and commit:
  - Before the commit edge: cfg_full=1.
  - With east_in=8'b0010_1010: control_input=6'b10_1010 combinationally.
  - After commit: counter=0, so cfg_full=0.
- Output 0 with sel=12, en=1, reg=1; toggle west_in[4] 0→1 at cycle t → control_input[0] rises at t+1, not at t.
- Output 3 with en=0 and any sel, all tracks=1 → control_input[3]=0.
- Error cases:
  - Commit after only 35 shifts → active unchanged, cfg_err high exactly 1 cycle.
  - Shift plus commit in the same cycle → shift occurs (counter+1), commit rejected, cfg_err pulses.
- Daisy chain of two instances, 72 shifts then a common commit → both configs correct. Asserting rst at shift 20 of a new frame → control_input=0, counter=0, cfg_out=0.
